// File: rtl/rom_burst_reader_pkg.sv
// rtl/rom_burst_reader_pkg.sv - shared constants for the ROM burst reader
package rom_burst_reader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  function automatic int burst_limit(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int BURST_LIMIT = burst_limit(ADDR_W_DEF);

endpackage

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - streams a wrapping burst of ROM words over valid/ready
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(burst_limit(ADDR_W));
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   REM_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]      state;
  logic [ADDR_W:0] rem;

  assign busy     = (state != IDLE);
  assign out_last = out_valid & (rem == REM_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= REM_ZERO;
      rom_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == REM_ZERO) begin
              done <= 1'b1;
            end else begin
              rem      <= (len > LIMIT) ? LIMIT : len;
              rom_addr <= base;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            rem   <= REM_ZERO;
            state <= IDLE;
          end else begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            rom_addr  <= rom_addr + ADDR_ONE;
            state     <= STREAM;
          end
        end
        STREAM: begin
          // Abort wins over a same-cycle handshake: that word is dropped.
          if (abort) begin
            out_valid <= 1'b0;
            rem       <= REM_ZERO;
            state     <= IDLE;
          end else if (out_valid && out_ready) begin
            if (rem > REM_ONE) begin
              out_data <= rom_data;
              rom_addr <= rom_addr + ADDR_ONE;
              rem      <= rem - REM_ONE;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              rem       <= REM_ZERO;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          rem       <= REM_ZERO;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - randomized and directed checks of rom_burst_reader against a word-list model
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base;
  logic [4:0] len;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  bit         ready_pat[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input int a);
    return 8'(8'hA0 + (a % 16));
  endfunction

  assign rom_data = rom_word(int'(rom_addr));

  rom_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One burst: rmode 0 = always ready, 1 = random ready; ready_pat overrides while non-empty.
  task automatic burst(input int b, input int l, input int rmode, input int abort_at, input bit noise);
    int  n;
    int  sent;
    int  cycles;
    bit  finished;
    bit  r;
    bit  ab;
    n = (l > 16) ? 16 : l;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(rom_word(b + i));
    check("idle_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    base  = 4'(b);
    len   = 5'(l);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("zero_len_done", 32'(done), 32'd1);
      check("zero_len_busy", 32'(busy), 32'd0);
      check("zero_len_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("zero_len_done_width", 32'(done), 32'd0);
      return;
    end
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_in_load", 32'(out_valid), 32'd0);
    @(negedge clk);
    sent = 0;
    cycles = 0;
    finished = 1'b0;
    while (!finished && cycles < 300) begin
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(exp_q[0]));
      check("stream_last", 32'(out_last), 32'(exp_q.size() == 1));
      check("stream_done_low", 32'(done), 32'd0);
      if (ready_pat.size() > 0) r = ready_pat.pop_front();
      else if (rmode == 1) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      ab = (sent == abort_at);
      if (ab) r = 1'b1;
      out_ready = r;
      abort = ab;
      if (noise && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        base  = 4'($urandom);
        len   = 5'($urandom);
      end
      @(negedge clk);
      cycles++;
      abort = 1'b0;
      start = 1'b0;
      if (ab) begin
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_no_done_late", 32'(done), 32'd0);
        finished = 1'b1;
      end else if (r) begin
        void'(exp_q.pop_front());
        sent++;
        if (exp_q.size() == 0) begin
          check("end_done", 32'(done), 32'd1);
          check("end_busy", 32'(busy), 32'd0);
          check("end_valid", 32'(out_valid), 32'd0);
          finished = 1'b1;
        end
      end
    end
    if (!finished) check("burst_timeout", 32'd1, 32'd0);
    out_ready = 1'b1;
    ready_pat.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base = '0;
    len = '0;
    abort = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, wrap/clamp, backpressure
    burst(2, 3, 0, -1, 1'b0);
    @(negedge clk);
    burst(14, 20, 0, -1, 1'b0);
    @(negedge clk);
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    burst(0, 4, 0, -1, 1'b0);
    @(negedge clk);

    // Zero length, ignored starts while busy
    burst(7, 0, 0, -1, 1'b0);
    burst(9, 6, 1, -1, 1'b1);

    // Abort on the third word's handshake, then a one-word burst (back-to-back from done cycle)
    @(negedge clk);
    burst(5, 8, 0, 2, 1'b0);
    burst(0, 1, 0, -1, 1'b0);
    burst(3, 2, 0, -1, 1'b0);

    // Reset mid-burst clears outputs immediately and produces no done
    start = 1'b1;
    base = 4'd3;
    len = 5'd10;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_data", 32'(out_data), 32'd0);
    check("midreset_addr", 32'(rom_addr), 32'd0);
    check("midreset_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_done", 32'(done), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("post_reset_done2", 32'(done), 32'd0);

    // Randomized bursts with random ready, occasional abort and start noise
    for (int k = 0; k < 25; k++) begin
      int rb;
      int rl;
      int ra;
      rb = int'($urandom_range(0, 15));
      rl = int'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      burst(rb, rl, 1, ra, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Sequencer for the 16×8 combinational ROM (`rom_custom`). On a `start` command it reads a burst of up to 16 consecutive words from a base address, wrapping 15→0. It streams them out over a valid/ready interface at up to one word per clock and pulses `done` when the burst ends. It sits between the ROM and any consumer that wants sequential table data without driving addresses itself.

## Interface
- `ADDR_W`, 4, ROM address width. Burst limit is 2^ADDR_W words.
- `DATA_W`, 8, ROM data width.
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: burst request. Sampled only while `busy`=0.
- `base` in ADDR_W: first address of the burst. Captured with `start`.
- `len` in ADDR_W+1: burst length in words. Captured with `start`.
- `abort` in 1: synchronous cancel of the burst in progress.
- `busy` out 1: high from the cycle after an accepted `start` until the burst ends.
- `done` out 1: one-cycle pulse at normal completion.
- `rom_addr` out ADDR_W: registered address to the ROM.
- `rom_data` in DATA_W: combinational ROM data for `rom_addr`.
- `out_data` out DATA_W: streamed word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the consumer accepts the word.
- `out_last` out 1: high with `out_valid` on the final word.

## Operation
- FSM states are IDLE, LOAD and STREAM.
- **IDLE:** `busy`=0, `out_valid`=0.
  - `start`=1 with `len`=0: `done` pulses on the next cycle; the FSM stays in IDLE.
  - `start`=1 with `len`≥1: capture `rem` = min(`len`, 16), set `rom_addr` ← `base`, go to LOAD.
- **LOAD (one cycle):** `out_data` ← `rom_data`, `out_valid` ← 1, `rom_addr` ← `rom_addr`+1 (mod 16), go to STREAM.
- **STREAM:** a handshake is `out_valid` & `out_ready`.
  - Handshake with `rem`>1: `out_data` ← `rom_data` (the prefetched next word), `rom_addr` ← `rom_addr`+1 (mod 16), `rem` ← `rem`−1. `out_valid` stays 1.
  - Handshake with `rem`=1: `out_valid` ← 0, `done` pulses next cycle, go to IDLE.
  - No handshake: `out_data`, `out_valid`, `out_last` and `rom_addr` hold. `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- `out_last` = `out_valid` & (`rem`=1).
- `abort`=1 in LOAD or STREAM: next cycle `out_valid`=0 and the FSM is in IDLE, with no `done`. `abort` takes priority over a simultaneous handshake; that word counts as not transferred. `abort` in IDLE is ignored.
- `start` while `busy`=1 is ignored. There is no queuing.
- `len` values 17..31 clamp to 16. A 16-word burst reads every address exactly once.
- Address increment is modulo 2^ADDR_W, e.g. `base`=14, `len`=4 reads 14, 15, 0, 1.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `rom_addr`=0, FSM in IDLE, `rem`=0.
- Reset asserted mid-burst clears all of the above immediately; no `done`.
- Latency: `start` sampled at edge N. `busy`=1 after N. `out_valid`=1 with word 0 after edge N+1.
- Throughput: one word per cycle while `out_ready`=1.
- `done` rises after the edge following the last handshake and lasts exactly one cycle. `busy` falls on the same edge.
- A new `start` is accepted in the cycle `done` is high. Back-to-back bursts therefore have one idle cycle.
- `rom_addr` changes only on clock edges. No combinational path runs from `out_ready` to `rom_addr`.

## Structure
- Shared package/include holds:
  - the state encoding: IDLE=2'd0, LOAD=2'd1, STREAM=2'd2;
  - the ADDR_W/DATA_W defaults;
  - the burst-limit constant 2^ADDR_W.
- Single module with no sub-modules. The ROM stays external and is instantiated beside the reader in the integration top and the bench.

## Test plan
Bench ROM model: M[a] = 8'hA0 + a.
- **Reset:** `rst_n` low mid-burst → all outputs 0 in the same cycle, FSM in IDLE. After release, no `done`.
- **Basic burst:** `base`=2, `len`=3, `out_ready`=1 → `out_data` A2, A3, A4 on consecutive cycles starting 2 cycles after `start`. `out_last` on A4, `done` one cycle later, `busy` low with it.
- **Wrap and clamp:** `base`=14, `len`=20 → 16 words AE, AF, A0 … AD. `out_last` on AD.
- **Backpressure:** `base`=0, `len`=4, `out_ready` toggled 1,0,0,1,0,1,1 → A0..A3 each transferred exactly once, in order. `out_data` is stable during stalls.
- **Zero length / ignored start:**
  - `len`=0 → `done` pulse, no `out_valid`.
  - `start` pulses during a busy burst → the burst is unaffected.
- **Abort:** `base`=5, `len`=8, `abort` asserted together with the handshake of the third word → no `done` pulse, `out_valid` low next cycle. A new `start` (`base`=0, `len`=1) then yields A0 and `done`.
